// File: rtl/id_pkg.sv
// id_pkg: opcode constants, ALU op/sub-op encodings and the RV32I field decoder
// shared by the ID stage and its forwarding matchers.
// Encodings are chosen so that an all-zero value is a NOP in both ALU fields.
package id_pkg;

  localparam int ALUOP_W  = 3;
  localparam int ALUSEL_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Operation class
  localparam logic [ALUOP_W-1:0] ALUOP_NOP    = 3'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_ARITH  = 3'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_LOGIC  = 3'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_SHIFT  = 3'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 3'd4;
  localparam logic [ALUOP_W-1:0] ALUOP_JUMP   = 3'd5;
  localparam logic [ALUOP_W-1:0] ALUOP_LOAD   = 3'd6;
  localparam logic [ALUOP_W-1:0] ALUOP_STORE  = 3'd7;

  // Sub-operation
  localparam logic [ALUSEL_W-1:0] ALUSEL_NOP   = 5'd0;
  localparam logic [ALUSEL_W-1:0] ALUSEL_ADD   = 5'd1;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SUB   = 5'd2;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SLT   = 5'd3;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SLTU  = 5'd4;
  localparam logic [ALUSEL_W-1:0] ALUSEL_XOR   = 5'd5;
  localparam logic [ALUSEL_W-1:0] ALUSEL_OR    = 5'd6;
  localparam logic [ALUSEL_W-1:0] ALUSEL_AND   = 5'd7;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SLL   = 5'd8;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SRL   = 5'd9;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SRA   = 5'd10;
  localparam logic [ALUSEL_W-1:0] ALUSEL_LUI   = 5'd11;
  localparam logic [ALUSEL_W-1:0] ALUSEL_AUIPC = 5'd12;
  localparam logic [ALUSEL_W-1:0] ALUSEL_JAL   = 5'd13;
  localparam logic [ALUSEL_W-1:0] ALUSEL_JALR  = 5'd14;
  localparam logic [ALUSEL_W-1:0] ALUSEL_BEQ   = 5'd15;
  localparam logic [ALUSEL_W-1:0] ALUSEL_BNE   = 5'd16;
  localparam logic [ALUSEL_W-1:0] ALUSEL_BLT   = 5'd17;
  localparam logic [ALUSEL_W-1:0] ALUSEL_BGE   = 5'd18;
  localparam logic [ALUSEL_W-1:0] ALUSEL_BLTU  = 5'd19;
  localparam logic [ALUSEL_W-1:0] ALUSEL_BGEU  = 5'd20;
  localparam logic [ALUSEL_W-1:0] ALUSEL_LB    = 5'd21;
  localparam logic [ALUSEL_W-1:0] ALUSEL_LH    = 5'd22;
  localparam logic [ALUSEL_W-1:0] ALUSEL_LW    = 5'd23;
  localparam logic [ALUSEL_W-1:0] ALUSEL_LBU   = 5'd24;
  localparam logic [ALUSEL_W-1:0] ALUSEL_LHU   = 5'd25;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SB    = 5'd26;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SH    = 5'd27;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SW    = 5'd28;

  typedef struct packed {
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [31:0]         imm;
    logic                wreg;
    logic [4:0]          wd;
    logic                uses_rs1;
    logic                uses_rs2;
    logic                illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t        d;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    f3    = inst[14:12];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    d     = '0;
    d.wd  = inst[11:7];
    case (inst[6:0])
      OPC_LUI:   begin d.aluop = ALUOP_ARITH; d.alusel = ALUSEL_LUI;   d.imm = imm_u; d.wreg = 1'b1; end
      OPC_AUIPC: begin d.aluop = ALUOP_ARITH; d.alusel = ALUSEL_AUIPC; d.imm = imm_u; d.wreg = 1'b1; end
      OPC_JAL:   begin d.aluop = ALUOP_JUMP;  d.alusel = ALUSEL_JAL;   d.imm = imm_j; d.wreg = 1'b1; end
      OPC_JALR: begin
        d.aluop = ALUOP_JUMP; d.alusel = ALUSEL_JALR; d.imm = imm_i;
        d.wreg = 1'b1; d.uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        d.aluop = ALUOP_BRANCH; d.imm = imm_b; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
        case (f3)
          3'b000:  d.alusel = ALUSEL_BEQ;
          3'b001:  d.alusel = ALUSEL_BNE;
          3'b100:  d.alusel = ALUSEL_BLT;
          3'b101:  d.alusel = ALUSEL_BGE;
          3'b110:  d.alusel = ALUSEL_BLTU;
          3'b111:  d.alusel = ALUSEL_BGEU;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.aluop = ALUOP_LOAD; d.imm = imm_i; d.uses_rs1 = 1'b1; d.wreg = 1'b1;
        case (f3)
          3'b000:  d.alusel = ALUSEL_LB;
          3'b001:  d.alusel = ALUSEL_LH;
          3'b010:  d.alusel = ALUSEL_LW;
          3'b100:  d.alusel = ALUSEL_LBU;
          3'b101:  d.alusel = ALUSEL_LHU;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d.aluop = ALUOP_STORE; d.imm = imm_s; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
        case (f3)
          3'b000:  d.alusel = ALUSEL_SB;
          3'b001:  d.alusel = ALUSEL_SH;
          3'b010:  d.alusel = ALUSEL_SW;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_OPIMM, OPC_OP: begin
        d.uses_rs1 = 1'b1; d.wreg = 1'b1;
        d.uses_rs2 = (inst[6:0] == OPC_OP);
        d.imm      = (inst[6:0] == OPC_OP) ? 32'd0 : imm_i;
        case (f3)
          3'b000: begin
            d.aluop  = ALUOP_ARITH;
            // inst[30] only means SUB on register-register ops; ADDI ignores it
            d.alusel = (d.uses_rs2 && inst[30]) ? ALUSEL_SUB : ALUSEL_ADD;
          end
          3'b001:  begin d.aluop = ALUOP_SHIFT; d.alusel = ALUSEL_SLL;  end
          3'b010:  begin d.aluop = ALUOP_ARITH; d.alusel = ALUSEL_SLT;  end
          3'b011:  begin d.aluop = ALUOP_ARITH; d.alusel = ALUSEL_SLTU; end
          3'b100:  begin d.aluop = ALUOP_LOGIC; d.alusel = ALUSEL_XOR;  end
          3'b101:  begin d.aluop = ALUOP_SHIFT; d.alusel = inst[30] ? ALUSEL_SRA : ALUSEL_SRL; end
          3'b110:  begin d.aluop = ALUOP_LOGIC; d.alusel = ALUSEL_OR;   end
          default: begin d.aluop = ALUOP_LOGIC; d.alusel = ALUSEL_AND;  end
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    // Illegal instructions travel as a NOP that only carries the flag
    if (d.illegal) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    if (d.wd == 5'd0) d.wreg = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: priority match of one operand address against NUM_FWD in-flight producers.
// Latency: combinational. Backpressure: none; not_rdy tells the stage to stall.
// Ports: addr/rf_data (operand + regfile value), fwd_* (flattened producer vectors,
// index 0 youngest), data (resolved operand), not_rdy (matched producer has no data yet).
module id_fwd_mux #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int NUM_FWD = 2
) (
  input  logic [RADDR_W-1:0]         addr,
  input  logic [XLEN-1:0]            rf_data,
  input  logic [NUM_FWD-1:0]         fwd_wreg,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_wd,
  input  logic [NUM_FWD-1:0]         fwd_rdy,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_wdata,
  output logic [XLEN-1:0]            data,
  output logic                       not_rdy
);

  logic hit;

  always_comb begin
    hit     = 1'b0;
    data    = rf_data;
    not_rdy = 1'b0;
    if (addr == '0) begin
      // x0 is hardwired; a producer claiming to write it must not leak through
      data = '0;
    end else begin
      for (int k = 0; k < NUM_FWD; k++) begin
        if (!hit && fwd_wreg[k] && (fwd_wd[k*RADDR_W +: RADDR_W] == addr)) begin
          hit     = 1'b1;
          data    = fwd_wdata[k*XLEN +: XLEN];
          not_rdy = !fwd_rdy[k];
        end
      end
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I decode with operand forwarding and an owned ID/EX register.
// Latency: 1 cycle from acceptance to out_valid_o.
// Backpressure: holds while EX stalls; drops in_ready_o on load-use hazards (bubble issued).
// Ports: IF side (in_valid_i/in_ready_o/pc_i/inst_i), regfile (rs*_addr_o/rs*_data_i),
// producers (fwd_*), EX side (out_valid_o/out_ready_i + registered fields), flush_i, stall_cnt_o.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [31:0]                inst_i,
  input  logic                       flush_i,
  output logic [RADDR_W-1:0]         rs1_addr_o,
  output logic [RADDR_W-1:0]         rs2_addr_o,
  input  logic [XLEN-1:0]            rs1_data_i,
  input  logic [XLEN-1:0]            rs2_data_i,
  input  logic [NUM_FWD-1:0]         fwd_wreg_i,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD-1:0]         fwd_rdy_i,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_wdata_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            pc_o,
  output logic [XLEN-1:0]            imm_o,
  output logic [XLEN-1:0]            reg1_o,
  output logic [XLEN-1:0]            reg2_o,
  output logic [ALUOP_W-1:0]         aluop_o,
  output logic [ALUSEL_W-1:0]        alusel_o,
  output logic                       wreg_o,
  output logic [RADDR_W-1:0]         wd_o,
  output logic                       illegal_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  dec_t            dec;
  logic [XLEN-1:0] op1_data, op2_data;
  logic            op1_nr, op2_nr;
  logic            stall, adv;

  assign dec        = decode(inst_i);
  assign rs1_addr_o = RADDR_W'(inst_i[19:15]);
  assign rs2_addr_o = RADDR_W'(inst_i[24:20]);

  id_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .addr(rs1_addr_o), .rf_data(rs1_data_i),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_rdy(fwd_rdy_i), .fwd_wdata(fwd_wdata_i),
    .data(op1_data), .not_rdy(op1_nr)
  );

  id_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .addr(rs2_addr_o), .rf_data(rs2_data_i),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_rdy(fwd_rdy_i), .fwd_wdata(fwd_wdata_i),
    .data(op2_data), .not_rdy(op2_nr)
  );

  // Only operands the instruction actually reads can create a hazard
  assign stall      = in_valid_i && ((dec.uses_rs1 && op1_nr) || (dec.uses_rs2 && op2_nr));
  assign adv        = !out_valid_o || out_ready_i;
  // During a flush the incoming instruction is always consumed (and discarded)
  assign in_ready_o = flush_i || (adv && !stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      pc_o        <= '0;
      imm_o       <= '0;
      reg1_o      <= '0;
      reg2_o      <= '0;
      aluop_o     <= ALUOP_NOP;
      alusel_o    <= ALUSEL_NOP;
      wreg_o      <= 1'b0;
      wd_o        <= '0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (adv) begin
      if (in_valid_i && !stall) begin
        out_valid_o <= 1'b1;
        pc_o        <= pc_i;
        imm_o       <= XLEN'($signed(dec.imm));
        reg1_o      <= dec.uses_rs1 ? op1_data : '0;
        reg2_o      <= dec.uses_rs2 ? op2_data : '0;
        aluop_o     <= dec.aluop;
        alusel_o    <= dec.alusel;
        wreg_o      <= dec.wreg;
        wd_o        <= RADDR_W'(dec.wd);
        illegal_o   <= dec.illegal;
      end else begin
        // Either a hazard bubble or nothing offered by IF
        out_valid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (in_valid_i && stall && !flush_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o;
  logic [31:0] pc_i, inst_i;
  logic        flush_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [1:0]  fwd_wreg_i, fwd_rdy_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] pc_o, imm_o, reg1_o, reg2_o;
  logic [ALUOP_W-1:0]  aluop_o;
  logic [ALUSEL_W-1:0] alusel_o;
  logic        wreg_o, illegal_o;
  logic [4:0]  wd_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  id_stage_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_rdy_i(fwd_rdy_i), .fwd_wdata_i(fwd_wdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .imm_o(imm_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .wreg_o(wreg_o), .wd_o(wd_o),
    .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic wreg, input logic [4:0] wd,
                         input logic rdy, input logic [31:0] data);
    fwd_wreg_i[k]           = wreg;
    fwd_wd_i[k*5 +: 5]      = wd;
    fwd_rdy_i[k]            = rdy;
    fwd_wdata_i[k*32 +: 32] = data;
  endtask

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; pc_i = '0; inst_i = '0; flush_i = 1'b0;
    rs1_data_i = '0; rs2_data_i = '0; out_ready_i = 1'b1;
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_rdy_i = '0; fwd_wdata_i = '0;
    tick(); tick();

    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    chk("rst_aluop", {29'd0, aluop_o}, {29'd0, ALUOP_NOP});
    chk("rst_alusel", {27'd0, alusel_o}, {27'd0, ALUSEL_NOP});
    chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst_cnt", stall_cnt_o, 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,5
    in_valid_i = 1'b1; pc_i = 32'h100; inst_i = 32'h00500093; rs1_data_i = 32'hDEAD;
    #1 chk("addi_in_ready", {31'd0, in_ready_o}, 32'd1);
    tick();
    chk("addi_valid", {31'd0, out_valid_o}, 32'd1);
    chk("addi_imm", imm_o, 32'd5);
    chk("addi_reg1", reg1_o, 32'd0);
    chk("addi_wd", {27'd0, wd_o}, 32'd1);
    chk("addi_wreg", {31'd0, wreg_o}, 32'd1);
    chk("addi_pc", pc_o, 32'h100);
    chk("addi_alusel", {27'd0, alusel_o}, {27'd0, ALUSEL_ADD});

    // ADD x3,x1,x2: both sources match x1, youngest wins
    pc_i = 32'h104; inst_i = 32'h002081B3; rs1_data_i = 32'h55; rs2_data_i = 32'd4;
    set_src(0, 1'b1, 5'd1, 1'b1, 32'd7);
    set_src(1, 1'b1, 5'd1, 1'b1, 32'd9);
    #1 chk("add_rs1_addr", {27'd0, rs1_addr_o}, 32'd1);
    chk("add_rs2_addr", {27'd0, rs2_addr_o}, 32'd2);
    tick();
    chk("add_reg1", reg1_o, 32'd7);
    chk("add_reg2", reg2_o, 32'd4);
    chk("add_alusel", {27'd0, alusel_o}, {27'd0, ALUSEL_ADD});
    chk("add_wd", {27'd0, wd_o}, 32'd3);

    // LW x5,0(x1) from the regfile
    pc_i = 32'h108; inst_i = 32'h0000A283; rs1_data_i = 32'h20;
    set_src(0, 1'b0, 5'd0, 1'b0, 32'd0);
    set_src(1, 1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    chk("lw_reg1", reg1_o, 32'h20);
    chk("lw_alusel", {27'd0, alusel_o}, {27'd0, ALUSEL_LW});
    chk("lw_aluop", {29'd0, aluop_o}, {29'd0, ALUOP_LOAD});

    // ADD x6,x5,x5 while the load is in EX without data: bubble
    pc_i = 32'h10C; inst_i = 32'h00528333;
    set_src(0, 1'b1, 5'd5, 1'b0, 32'h0);
    #1 chk("lu_in_ready", {31'd0, in_ready_o}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, out_valid_o}, 32'd0);
    chk("lu_cnt", stall_cnt_o, 32'd1);
    // Load data now available from the older source
    set_src(0, 1'b0, 5'd0, 1'b0, 32'h0);
    set_src(1, 1'b1, 5'd5, 1'b1, 32'h10);
    #1 chk("lu2_in_ready", {31'd0, in_ready_o}, 32'd1);
    tick();
    chk("lu2_valid", {31'd0, out_valid_o}, 32'd1);
    chk("lu2_reg1", reg1_o, 32'h10);
    chk("lu2_reg2", reg2_o, 32'h10);
    chk("lu2_cnt", stall_cnt_o, 32'd1);

    // A producer claiming x0 (not ready) neither forwards nor stalls
    pc_i = 32'h110; inst_i = 32'h00500093; rs1_data_i = 32'hDEAD;
    set_src(0, 1'b1, 5'd0, 1'b0, 32'hFF);
    set_src(1, 1'b0, 5'd0, 1'b0, 32'h0);
    #1 chk("x0_in_ready", {31'd0, in_ready_o}, 32'd1);
    tick();
    chk("x0_reg1", reg1_o, 32'd0);

    // Forwarded value 0 must beat a nonzero regfile value
    pc_i = 32'h114; inst_i = 32'h002081B3; rs1_data_i = 32'h1234; rs2_data_i = 32'd4;
    set_src(0, 1'b1, 5'd1, 1'b1, 32'd0);
    tick();
    chk("fz_reg1", reg1_o, 32'd0);
    chk("fz_reg2", reg2_o, 32'd4);

    // BEQ x1,x2,+8 then EX backpressure for 3 cycles
    pc_i = 32'h118; inst_i = 32'h00208463; rs1_data_i = 32'hA; rs2_data_i = 32'hB;
    set_src(0, 1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    chk("beq_imm", imm_o, 32'd8);
    chk("beq_wreg", {31'd0, wreg_o}, 32'd0);
    chk("beq_reg2", reg2_o, 32'hB);
    out_ready_i = 1'b0; pc_i = 32'h200; inst_i = 32'h00500093;
    #1 chk("hold_in_ready", {31'd0, in_ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", {31'd0, out_valid_o}, 32'd1);
      chk("hold_pc", pc_o, 32'h118);
      chk("hold_imm", imm_o, 32'd8);
    end
    flush_i = 1'b1;
    #1 chk("flush_in_ready", {31'd0, in_ready_o}, 32'd1);
    tick();
    chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
    flush_i = 1'b0; out_ready_i = 1'b1;

    // Unknown opcode
    pc_i = 32'h300; inst_i = 32'hFFFFFFFF;
    tick();
    chk("ill_valid", {31'd0, out_valid_o}, 32'd1);
    chk("ill_flag", {31'd0, illegal_o}, 32'd1);
    chk("ill_wreg", {31'd0, wreg_o}, 32'd0);
    chk("ill_aluop", {29'd0, aluop_o}, {29'd0, ALUOP_NOP});
    chk("ill_pc", pc_o, 32'h300);

    // Stall again, then reset in the middle of it
    pc_i = 32'h304; inst_i = 32'h00528333;
    set_src(0, 1'b1, 5'd5, 1'b0, 32'h0);
    tick();
    chk("st2_cnt", stall_cnt_o, 32'd2);
    rst = 1'b1;
    tick();
    chk("rst2_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst2_pc", pc_o, 32'd0);
    chk("rst2_illegal", {31'd0, illegal_o}, 32'd0);
    chk("rst2_cnt", stall_cnt_o, 32'd0);
    rst = 1'b0; in_valid_i = 1'b0;
    set_src(0, 1'b0, 5'd0, 1'b0, 32'h0);
    tick();
    chk("idle_valid", {31'd0, out_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
